// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: state encoding, default sizes and counter sizing
// shared by the serial frame transmitter and its matching receiver.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    SF_IDLE   = 3'd0,
    SF_START  = 3'd1,
    SF_DATA   = 3'd2,
    SF_PARITY = 3'd3,
    SF_GAP    = 3'd4
  } sf_state_e;

  localparam int SF_DATA_W  = 8;
  localparam int SF_GAP_CYC = 2;

  function automatic int sf_cnt_w(input int dw, input int gc);
    int m;
    m = ((dw > gc) ? dw : gc) - 1;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/serial_frame_tx_counter.sv
// sf_down_counter: loadable down-counter with zero flag, shared by
// the data and gap phases of the frame transmitter.
module sf_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start bit, LSB-first data, optional even parity
// (SERIAL_FRAME_TX_PARITY_EN), then a forced-low gap.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W  = SF_DATA_W,
  parameter int GAP_CYC = SF_GAP_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_data,
  output logic              din_ready,
  output logic              x,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = sf_cnt_w(DATA_W, GAP_CYC);
  localparam logic [CW-1:0] DLOAD = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GLOAD = CW'(GAP_CYC - 1);

  sf_state_e         state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              x_q, x_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]     cnt_val, cnt;
  logic              accept, shift;

  assign din_ready = (state_q == SF_IDLE) && !reset;
  assign accept    = din_valid && din_ready;

  sf_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = 1'b0;
    end else if (shift) begin
      par_d = par_q ^ sr_q[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    x_d      = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = DLOAD;
    cnt_dec  = 1'b0;
    shift    = 1'b0;
    case (state_q)
      SF_IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          sr_d     = din_data;
          cnt_load = 1'b1;
          state_d  = SF_START;
          x_d      = 1'b1;
          busy_d   = 1'b1;
        end
      end
      SF_START: begin
        x_d     = sr_q[0];
        sr_d    = sr_q >> 1;
        shift   = 1'b1;
        state_d = SF_DATA;
      end
      SF_DATA: begin
        if (cnt_zero) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_d  = SF_PARITY;
          x_d      = par_q;
`else
          state_d  = SF_GAP;
          cnt_load = 1'b1;
          cnt_val  = GLOAD;
          done_d   = (GAP_CYC == 1);
`endif
        end else begin
          x_d     = sr_q[0];
          sr_d    = sr_q >> 1;
          shift   = 1'b1;
          cnt_dec = 1'b1;
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      SF_PARITY: begin
        state_d  = SF_GAP;
        cnt_load = 1'b1;
        cnt_val  = GLOAD;
        done_d   = (GAP_CYC == 1);
      end
`endif
      SF_GAP: begin
        if (cnt_zero) begin
          state_d = SF_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_dec = 1'b1;
          done_d  = (cnt == CW'(1));
        end
      end
      default: begin
        state_d = SF_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SF_IDLE;
      sr_q    <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x          = x_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: random words against a per-cycle frame model,
// plus a DATA_W=1/GAP_CYC=1 instance for the minimum-size frame.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int DW = 8;
  localparam int GC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din_data = '0;
  logic          din_ready, x, busy, frame_done;

  logic       v1 = 1'b0;
  logic [0:0] d1 = 1'b0;
  logic       r1, x1, b1, f1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(DW), .GAP_CYC(GC)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .din_valid  (din_valid),
    .din_data   (din_data),
    .din_ready  (din_ready),
    .x          (x),
    .busy       (busy),
    .frame_done (frame_done)
  );

  serial_frame_tx #(.DATA_W(1), .GAP_CYC(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .din_valid  (v1),
    .din_data   (d1),
    .din_ready  (r1),
    .x          (x1),
    .busy       (b1),
    .frame_done (f1)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_len(input int dw, input int gc);
    return 1 + dw + P + gc;
  endfunction

  // Line level at offset j after accept, from the frame format alone.
  function automatic int frame_bit(input logic [15:0] d, input int dw,
                                   input int j);
    int ones;
    ones = 0;
    for (int i = 0; i < dw; i++) ones += int'(d[i]);
    if (j == 0) return 1;
    if (j <= dw) return int'(d[j-1]);
    if (P == 1 && j == dw + 1) return ones % 2;
    return 0;
  endfunction

  task automatic check_idle(input string tag);
    expect_eq({tag, "_x"}, x, 0);
    expect_eq({tag, "_busy"}, busy, 0);
    expect_eq({tag, "_done"}, frame_done, 0);
    expect_eq({tag, "_ready"}, din_ready, 1);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic send(input logic [DW-1:0] d, input int rst_at);
    int len;
    len = frame_len(DW, GC);
    expect_eq("ready_pre", din_ready, 1);
    din_valid = 1'b1;
    din_data  = d;
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      din_valid = 1'($urandom_range(0, 1));
      din_data  = DW'($urandom);
      if (j == len - 1) din_valid = 1'b0;
      expect_eq("x", x, frame_bit(16'(d), DW, j));
      expect_eq("busy", busy, 1);
      expect_eq("done", frame_done, (j == len - 1) ? 1 : 0);
      expect_eq("ready_busy", din_ready, 0);
      if (j == rst_at) begin
        reset     = 1'b1;
        din_valid = 1'b0;
        #1;
        expect_eq("rst_x", x, 0);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_done", frame_done, 0);
        expect_eq("rst_ready", din_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle("post_rst");
        @(negedge clk);
        check_idle("post_rst2");
        return;
      end
    end
    @(negedge clk);
    check_idle("idle_after");
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len1;
    int rst_at;
    repeat (2) @(negedge clk);
    expect_eq("rst_hold_x", x, 0);
    expect_eq("rst_hold_busy", busy, 0);
    expect_eq("rst_hold_ready", din_ready, 0);
    expect_eq("rst_hold_done", frame_done, 0);
    reset = 1'b0;
    #1;
    expect_eq("ready_release", din_ready, 1);
    repeat (5) begin
      @(negedge clk);
      check_idle("idle5");
    end

    send(8'hA5, -1);
    send(8'h07, -1);
    send(8'hFF, -1);
    send(8'h00, -1);
    repeat (2) begin
      @(negedge clk);
      check_idle("idle2");
    end
    send(8'hA5, 4);
    send(8'h3C, -1);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_idle("rnd_idle");
      end
      rst_at = -1;
      if ($urandom_range(0, 7) == 0)
        rst_at = $urandom_range(0, frame_len(DW, GC) - 1);
      send(DW'($urandom), rst_at);
    end

    len1 = frame_len(1, 1);
    expect_eq("w1_ready", r1, 1);
    v1 = 1'b1;
    d1 = 1'b1;
    for (int j = 0; j < len1; j++) begin
      @(negedge clk);
      v1 = 1'b0;
      expect_eq("w1_x", x1, frame_bit(16'h1, 1, j));
      expect_eq("w1_busy", b1, 1);
      expect_eq("w1_done", f1, (j == len1 - 1) ? 1 : 0);
    end
    @(negedge clk);
    expect_eq("w1_idle_x", x1, 0);
    expect_eq("w1_idle_busy", b1, 0);
    expect_eq("w1_idle_ready", r1, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that drives the single-bit `x` line consumed by the team's Mealy frame-detect receivers. It accepts a parallel word over a valid/ready handshake and serialises it as a frame: a high start bit, the data LSB-first, an optional even-parity bit, then a forced-low inter-frame gap. It sits between a word source (test sequencer or register bank) and the serial line into the receiver FSM.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 1..16.
- `GAP_CYC`, default 2: low cycles after each frame; legal range 1..15. A value of 0 is illegal; the receiver needs at least one low cycle before it can detect the next start bit.

- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `din_valid`  input  1  source has a word on `din_data`.
- `din_data`  input  DATA_W  word to send; sampled only on accept.
- `din_ready`  output  1  block can accept a word.
- `x`  output  1  serial line, registered.
- `busy`  output  1  a frame is in progress (START through GAP).
- `frame_done`  output  1  one-cycle pulse marking the last gap cycle.

## Operation
- States: IDLE, START, DATA, PARITY (only when the parity feature is compiled in), GAP.
- IDLE: `x`=0, `busy`=0, `din_ready`=1. On `din_valid`&&`din_ready` at a clock edge (the "accept"):
  - `din_data` loads into the shift register.
  - The bit counter loads DATA_W-1.
  - The state moves to START.
- START: `x`=1 for exactly one cycle, then DATA.
- DATA: `x`=shift register bit 0. The register shifts right each cycle and the counter decrements. When the counter reaches 0 after its bit, the state moves to PARITY if parity is compiled in, otherwise to GAP.
- PARITY: `x`=XOR of all DATA_W captured bits (even parity) for one cycle, then GAP.
- GAP: `x`=0 for GAP_CYC cycles. The counter reloads GAP_CYC-1 on entry. `frame_done`=1 in the cycle the counter is 0, then IDLE.
- `din_ready` = (state==IDLE) && !reset. It is low in every other state.
- `din_valid` is ignored while `din_ready`=0. The source must hold its data until the accept.
- `busy`=1 in START, DATA, PARITY and GAP.
- Widths: the bit counter is wide enough for max(DATA_W, GAP_CYC)-1. The parity register is 1 bit and accumulates during DATA.

## Timing
- Reset values: `x`=0, `busy`=0, `frame_done`=0, `din_ready`=0 while `reset` is high, state IDLE. After reset deasserts, `din_ready`=1 combinationally.
- Accept at edge k gives:
  - `x`=1 in cycle k+1.
  - Data bit i in cycle k+2+i.
  - The parity bit in cycle k+2+DATA_W.
  - Then the gap.
- Frame length L = 1 + DATA_W + P + GAP_CYC cycles, where P=1 with parity and 0 without. The next accept can occur at the earliest one cycle after the last gap cycle (the IDLE cycle), so the minimum accept-to-accept period is L+1.
- Reset mid-frame: all outputs and state go to their reset values immediately (asynchronous). The partial frame is dropped, no `frame_done` is issued, and the held word is not resent.
- `din_valid` asserted in the same cycle `reset` falls: it is not accepted in that cycle, because `din_ready` was gated low at that edge.

## Configuration
- `SERIAL_FRAME_TX_PARITY_EN` defined: the PARITY state exists and frames carry an even-parity bit after the data (P=1).
- Macro undefined: no PARITY state and no parity register. DATA goes directly to GAP (P=0).

## Structure
- Shared package `serial_frame_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, GAP; 3-bit encoding),
  - default constants `SF_DATA_W=8` and `SF_GAP_CYC=2`,
  - a function computing the bit-counter width.

  The matching receiver reuses the same package.
- One sub-module, `sf_down_counter`: a loadable down-counter with a zero flag. It is shared between the DATA and GAP phases and its width is parameterised.

## Test plan
- Reset release, then idle for 5 cycles → `x`=0, `busy`=0, `din_ready`=1, no `frame_done`.
- DATA_W=8, GAP_CYC=2, parity compiled in; send 0xA5 → `x` per cycle from k+1 is 1 | 1,0,1,0,0,1,0,1 | 0 | 0,0. `frame_done` is high in the last 0 cycle and `din_ready` returns at k+13.
- Same configuration; send 0x07 → data bits 1,1,1,0,0,0,0,0, parity bit 1, frame length 12 cycles.
- Parity compiled out; back-to-back 0xFF then 0x00 with `din_valid` held high → second START exactly 12 cycles after the first accept (L=11, period 12). `din_valid` is ignored while `busy`.
- Assert `reset` during data bit 3 of 0xA5 → `x`, `busy` and `frame_done` are 0 in the same cycle. After release the next accepted word 0x3C transmits cleanly, with no residue from 0xA5.
- GAP_CYC=1, DATA_W=1, parity compiled in; send 0x1 → `x`=1,1,1,0, with `frame_done` in the fourth cycle.
